// File: rtl/ppu_pkg.sv
// Shared types for the PPU issue front end: operation codes, sequencer states and
// the result-metadata entry that travels from issue to the output FIFO.
package ppu_pkg;

    localparam int SEQ_TAG_W = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_FMA = 3'd4,
        OP_CMP = 3'd5
    } operation_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PIPE     = 2'd1,
        DIV_WAIT = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [SEQ_TAG_W-1:0] tag;
        operation_e           op;
        logic                 sign;
    } seq_entry_t;

    // Additive ops keep the sign of operand 1; everything else combines both signs.
    function automatic logic result_sign(operation_e op, logic sign1, logic sign2);
        return (op inside {OP_ADD, OP_SUB}) ? sign1 : (sign1 ^ sign2);
    endfunction

endpackage

// File: rtl/ppu_result_fifo.sv
// Circular result-metadata FIFO with a register-array head and an occupancy count
// that the sequencer uses for credit-based issue.
module ppu_result_fifo
    import ppu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  seq_entry_t             push_data_i,
    input  logic                   pop_i,
    output logic                   head_valid_o,
    output seq_entry_t             head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    seq_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering in simulation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // NOTE: the storage array has no reset; count_q alone decides which slots are live.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_valid_o = (count_q != '0);
    assign head_o       = mem_q[rd_ptr_q];
    assign count_o      = count_q;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        push_i |-> (count_q != CNT_W'(DEPTH)))
        else $error("push into full result FIFO");

endmodule

// File: rtl/ppu_op_sequencer.sv
// Issue controller for the PPU arithmetic core: steers ops to the fixed-latency
// datapath or the iterative divider and retires their metadata in order.
module ppu_op_sequencer
    import ppu_pkg::*;
#(
    parameter int PIPE_LAT  = 1,
    parameter int OUT_DEPTH = 4,
    parameter int TAG_W     = SEQ_TAG_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  operation_e       in_op_i,
    input  logic [TAG_W-1:0] in_tag_i,
    input  logic             in_sign1_i,
    input  logic             in_sign2_i,
    output logic             dp_issue_o,
    output operation_e       dp_op_o,
    output logic             div_start_o,
    input  logic             div_done_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [TAG_W-1:0] out_tag_o,
    output operation_e       out_op_o,
    output logic             out_sign_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
    localparam int SUM_W = $clog2(OUT_DEPTH + PIPE_LAT + 1) + 1;

    seq_state_e          state_q, state_d;
    seq_entry_t          pipe_q [PIPE_LAT];
    logic [PIPE_LAT-1:0] pipe_vld_q;
    seq_entry_t          div_entry_q;
    seq_entry_t          in_entry, push_entry, head_entry;
    logic [CNT_W-1:0]    fifo_count;
    logic [SUM_W-1:0]    pipe_inflight, occupancy;
    logic                is_div, div_wait, credits_ok, accept, fifo_push, fifo_pop;

    always_comb begin
        pipe_inflight = '0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            pipe_inflight = pipe_inflight + SUM_W'(pipe_vld_q[i]);
        end
    end

    // Every accepted op holds one credit from issue until its FIFO entry is popped.
    assign occupancy  = pipe_inflight + SUM_W'(div_wait) + SUM_W'(fifo_count);
    assign credits_ok = (occupancy < SUM_W'(OUT_DEPTH));
    assign is_div     = (in_op_i == OP_DIV);
    assign div_wait   = (state_q == DIV_WAIT);

    // A DIV must not overtake pipelined ops, so it waits for the pipe to drain.
    assign in_ready_o  = !rst_i && credits_ok && !div_wait && !(is_div && pipe_inflight != '0);
    assign accept      = in_valid_i && in_ready_o;
    assign dp_issue_o  = accept && !is_div;
    assign div_start_o = accept && is_div;
    assign dp_op_o     = in_op_i;

    assign in_entry = '{tag: in_tag_i, op: in_op_i, sign: result_sign(in_op_i, in_sign1_i, in_sign2_i)};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= dp_issue_o;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        pipe_q[0] <= in_entry;
        for (int i = 1; i < PIPE_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
        if (div_start_o) div_entry_q <= in_entry;
    end

    // Pipe and divider completions never coincide: a DIV only issues into an empty pipe.
    assign fifo_push  = pipe_vld_q[PIPE_LAT-1] || (div_wait && div_done_i);
    assign push_entry = pipe_vld_q[PIPE_LAT-1] ? pipe_q[PIPE_LAT-1] : div_entry_q;
    assign fifo_pop   = out_valid_o && out_ready_i;

    ppu_result_fifo #(
        .DEPTH (OUT_DEPTH)
    ) u_result_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (fifo_push),
        .push_data_i  (push_entry),
        .pop_i        (fifo_pop),
        .head_valid_o (out_valid_o),
        .head_o       (head_entry),
        .count_o      (fifo_count)
    );

    assign out_tag_o  = head_entry.tag;
    assign out_op_o   = head_entry.op;
    assign out_sign_o = head_entry.sign;
    assign busy_o     = (pipe_inflight != '0) || div_wait || (fifo_count != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = is_div ? DIV_WAIT : PIPE;
            end
            PIPE: begin
                if (accept)                   state_d = is_div ? DIV_WAIT : PIPE;
                else if (pipe_inflight == '0) state_d = IDLE;
            end
            DIV_WAIT: begin
                if (div_done_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    a_done_in_wait: assert property (@(posedge clk_i) disable iff (rst_i)
        div_done_i |-> div_wait)
        else $error("div_done_i outside DIV_WAIT is ignored");

endmodule
